freqdiv_ctrl: RTL and testbench
===============================

// Module: freqdiv_ctrl
// PURPOSE
//  Wishbone-programmed sequencer for the caravel user-area clock divider: owns divider enable/ratio.
//  Ratio changes and stop requests are applied only on the divider wrap boundary, so clkout never glitches.
//  Counts completed output periods. Sits between the WB slave port and the divider instance.
// PARAMETERS
//  NW    4   width of divide ratio (div_n_o); legal ratios 2..2**NW-1
//  PCW   16  width of period counter PCOUNT
//  WDOG  16  cycles allowed in PEND/STOP without div_wrap_i before forced transition
// PORTS
//  wb_clk_i     in   1     single clock; divider and this block both run on it
//  wb_rst_ni    in   1     asynchronous active-low reset
//  wbs_stb_i    in   1     WB strobe
//  wbs_cyc_i    in   1     WB cycle
//  wbs_we_i     in   1     WB write enable
//  wbs_sel_i    in   4     WB byte selects; only byte 0/1 lanes used
//  wbs_adr_i    in   32    WB address; [3:2] selects register
//  wbs_dat_i    in   32    WB write data
//  wbs_ack_o    out  1     WB ack
//  wbs_dat_o    out  32    WB read data
//  div_wrap_i   in   1     1-cycle pulse: divider posedge counter wrapped to 0
//  div_en_o     out  1     divider enable
//  div_n_o      out  NW    divider ratio
//  irq_o        out  1     interrupt (FREQDIV_IRQ_EN only)
// BEHAVIOUR
//  Reset: div_en_o=0, div_n_o=2, wbs_ack_o=0, wbs_dat_o=0, irq_o=0, all regs 0 except DIV=2, state IDLE.
//  WB: ack registered, high exactly 1 cycle after stb&cyc, then low 1 cycle (no back-to-back ack).
//  Regs: 0x0 CTRL [0]en_req [1]ie; 0x4 DIV [NW-1:0] req ratio; 0x8 STATUS RO except W1C bits:
//   [0]running [1]pending [2]err W1C [3]done W1C [11:8]active ratio; 0xC PCOUNT RO.
//  DIV write of 0 or 1: ignored, sets err. Unmapped reads return 0.
//  FSM: IDLE: en_req=1 -> div_n_o<=DIV, div_en_o<=1, PCOUNT<=0, RUN (outputs change cycle after ack).
//   RUN: en_req=0 -> STOP; legal DIV write != div_n_o -> PEND.
//   PEND: div_wrap_i -> div_n_o<=DIV, set done, RUN; en_req=0 -> STOP (pending dropped, DIV kept).
//   STOP: div_wrap_i -> div_en_o<=0, IDLE.
//   PEND/STOP watchdog: WDOG cycles with no div_wrap_i -> apply action anyway, set err.
//  Simultaneous DIV write and div_wrap_i in PEND: wrap applies pre-write DIV; new value re-arms PEND
//   next cycle if it differs from the applied ratio.
//  PCOUNT: +1 on div_wrap_i while div_en_o=1; saturates at 2**PCW-1; holds in IDLE.
//  en_req toggled 1->0->1 before STOP completes: STOP still waits for wrap, then IDLE restarts next cycle.
//  wb_rst_ni low mid-operation: immediate async return to reset values; divider output stops.
// CONFIGURATION
//  FREQDIV_IRQ_EN defined: irq_o = done & CTRL.ie, level, cleared by W1C of STATUS.done.
//  Not defined: irq_o tied 0, CTRL[1] not stored and reads 0; done bit still functions.
// STRUCTURE
//  Shared header freqdiv_defs.vh: register offsets, state encodings (IDLE/RUN/PEND/STOP),
//   RATIO_MIN=2, STATUS bit indices.
//  Sub-module freqdiv_wb_regs: WB decode, ack, CTRL/DIV storage, W1C handling; FSM+counters in top.
// TESTING
//  Reset release, read all regs -> CTRL=0, DIV=2, STATUS=0x200, PCOUNT=0, div_en_o=0.
//  Write DIV=6, CTRL=1 -> div_en_o=1, div_n_o=6 one cycle after ack; after 10 wraps PCOUNT=10.
//  Running at 6, write DIV=9 -> pending=1, div_n_o stays 6 until div_wrap_i, then 9, done=1.
//  Write DIV=1 -> DIV stays previous value, STATUS.err=1; W1C 0x4 to STATUS clears err.
//  Hold div_wrap_i low in PEND -> after 16 cycles ratio applied, err=1.
//  With FREQDIV_IRQ_EN and ie=1, ratio change -> irq_o=1 at done; W1C 0x8 -> irq_o=0; without macro irq_o stays 0.

Source files
------------

// File: rtl/freqdiv_pkg.sv
// Shared definitions for the freqdiv_ctrl slice: register map, STATUS/CTRL bit positions, FSM states.
// Optional interrupt support is selected with the FREQDIV_IRQ_EN macro (see freqdiv_wb_regs).
package freqdiv_pkg;

    localparam int RATIO_MIN = 2;

    // Word index taken from wbs_adr_i[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DIV    = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_PCOUNT = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IE      = 1;

    localparam int ST_RUNNING   = 0;
    localparam int ST_PENDING   = 1;
    localparam int ST_ERR       = 2;
    localparam int ST_DONE      = 3;
    localparam int ST_RATIO_LSB = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        STOP = 2'd3
    } state_e;

endpackage

// File: rtl/freqdiv_wb_regs.sv
// Wishbone slave for freqdiv_ctrl: decode, single-cycle registered ack, CTRL/DIV storage, W1C flags.
// CTRL.ie is only stored when FREQDIV_IRQ_EN is defined; otherwise it reads 0.
module freqdiv_wb_regs
    import freqdiv_pkg::*;
#(
    parameter int NW  = 4,
    parameter int PCW = 16
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_ni,
    input  logic           wbs_stb_i,
    input  logic           wbs_cyc_i,
    input  logic           wbs_we_i,
    input  logic [3:0]     wbs_sel_i,
    input  logic [31:0]    wbs_adr_i,
    input  logic [31:0]    wbs_dat_i,
    output logic           wbs_ack_o,
    output logic [31:0]    wbs_dat_o,
    input  logic           running,
    input  logic           pending,
    input  logic [NW-1:0]  active_n,
    input  logic [PCW-1:0] pcount,
    input  logic           set_err,
    input  logic           set_done,
    output logic           en_req,
    output logic           ie,
    output logic [NW-1:0]  div_req,
    output logic           done
);

    logic        access;
    logic        mapped;
    logic        wr_lane0;
    logic        wr_ctrl;
    logic        wr_div;
    logic        wr_status;
    logic        div_legal;
    logic        err_q;
    logic [31:0] rdata;
    logic        unused_bits;

    // Ack blocks a second access in the cycle it is high, so a held strobe is served every other cycle
    assign access    = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign mapped    = (wbs_adr_i[31:4] == '0);
    assign wr_lane0  = access & wbs_we_i & mapped & wbs_sel_i[0];
    assign wr_ctrl   = wr_lane0 & (wbs_adr_i[3:2] == REG_CTRL);
    assign wr_div    = wr_lane0 & (wbs_adr_i[3:2] == REG_DIV);
    assign wr_status = wr_lane0 & (wbs_adr_i[3:2] == REG_STATUS);
    assign div_legal = (wbs_dat_i[NW-1:0] >= NW'(RATIO_MIN));

    assign unused_bits = ^{wbs_sel_i, wbs_adr_i, wbs_dat_i};

    // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        rdata = '0;
        if (mapped) begin
            case (wbs_adr_i[3:2])
                REG_CTRL: begin
                    rdata[CTRL_EN] = en_req;
                    rdata[CTRL_IE] = ie;
                end
                REG_DIV:    rdata[NW-1:0] = div_req;
                REG_STATUS: begin
                    rdata[ST_RUNNING]            = running;
                    rdata[ST_PENDING]            = pending;
                    rdata[ST_ERR]                = err_q;
                    rdata[ST_DONE]               = done;
                    rdata[ST_RATIO_LSB +: NW]    = active_n;
                end
                REG_PCOUNT: rdata[PCW-1:0] = pcount;
                default:    rdata = '0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            en_req    <= 1'b0;
            div_req   <= NW'(RATIO_MIN);
            err_q     <= 1'b0;
            done      <= 1'b0;
        end else begin
            wbs_ack_o <= access;
            wbs_dat_o <= (access & ~wbs_we_i) ? rdata : '0;
            if (wr_ctrl)
                en_req <= wbs_dat_i[CTRL_EN];
            if (wr_div && div_legal)
                div_req <= wbs_dat_i[NW-1:0];
            // A hardware set in the same cycle as a W1C wins, so no event is lost
            if (set_err || (wr_div && !div_legal))
                err_q <= 1'b1;
            else if (wr_status && wbs_dat_i[ST_ERR])
                err_q <= 1'b0;
            if (set_done)
                done <= 1'b1;
            else if (wr_status && wbs_dat_i[ST_DONE])
                done <= 1'b0;
        end
    end

`ifdef FREQDIV_IRQ_EN
    logic ie_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            ie_q <= 1'b0;
        else if (wr_ctrl)
            ie_q <= wbs_dat_i[CTRL_IE];
    end

    assign ie = ie_q;
`else
    assign ie = 1'b0;
`endif

endmodule

// File: rtl/freqdiv_ctrl.sv
// Clock-divider sequencer: applies ratio changes and stops only on the divider wrap boundary.
// Interrupt output is live only when FREQDIV_IRQ_EN is defined; otherwise irq_o stays 0.
module freqdiv_ctrl
    import freqdiv_pkg::*;
#(
    parameter int NW   = 4,
    parameter int PCW  = 16,
    parameter int WDOG = 16
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          wbs_stb_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    input  logic          div_wrap_i,
    output logic          div_en_o,
    output logic [NW-1:0] div_n_o,
    output logic          irq_o
);

    localparam int WDW = $clog2(WDOG + 1);

    state_e         state, state_nx;
    logic [NW-1:0]  div_n_nx;
    logic           div_en_nx;
    logic [PCW-1:0] pcount;
    logic           clr_pcount;
    logic [WDW-1:0] wd_cnt;
    logic           wd_expired;
    logic           set_err;
    logic           set_done;
    logic           en_req;
    logic           ie;
    logic           done;
    logic [NW-1:0]  div_req;

    freqdiv_wb_regs #(
        .NW  (NW),
        .PCW (PCW)
    ) u_regs (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .running   (div_en_o),
        .pending   (state == PEND),
        .active_n  (div_n_o),
        .pcount    (pcount),
        .set_err   (set_err),
        .set_done  (set_done),
        .en_req    (en_req),
        .ie        (ie),
        .div_req   (div_req),
        .done      (done)
    );

    assign wd_expired = (wd_cnt == WDW'(WDOG - 1));
    assign irq_o      = done & ie;

    // A stop request takes priority over a pending ratio change in PEND
    always_comb begin
        state_nx   = state;
        div_n_nx   = div_n_o;
        div_en_nx  = div_en_o;
        clr_pcount = 1'b0;
        set_err    = 1'b0;
        set_done   = 1'b0;
        case (state)
            IDLE: begin
                if (en_req) begin
                    div_n_nx   = div_req;
                    div_en_nx  = 1'b1;
                    clr_pcount = 1'b1;
                    state_nx   = RUN;
                end
            end
            RUN: begin
                if (!en_req)
                    state_nx = STOP;
                else if (div_req != div_n_o)
                    state_nx = PEND;
            end
            PEND: begin
                if (!en_req) begin
                    state_nx = STOP;
                end else if (div_wrap_i || wd_expired) begin
                    div_n_nx = div_req;
                    set_done = 1'b1;
                    set_err  = ~div_wrap_i;
                    state_nx = RUN;
                end
            end
            STOP: begin
                if (div_wrap_i || wd_expired) begin
                    div_en_nx = 1'b0;
                    set_err   = ~div_wrap_i;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state    <= IDLE;
            div_n_o  <= NW'(RATIO_MIN);
            div_en_o <= 1'b0;
            wd_cnt   <= '0;
            pcount   <= '0;
        end else begin
            state    <= state_nx;
            div_n_o  <= div_n_nx;
            div_en_o <= div_en_nx;
            // Watchdog measures dwell time in the current wait state; any transition restarts it
            if ((state_nx != state) || !((state == PEND) || (state == STOP)))
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;
            if (clr_pcount)
                pcount <= '0;
            else if (div_wrap_i && div_en_o && (pcount != '1))
                pcount <= pcount + 1'b1;
        end
    end

endmodule

// File: tb/tb_freqdiv_ctrl.sv
// Self-checking bench for freqdiv_ctrl: reference model plus scoreboard of WB read responses.
// Honours FREQDIV_IRQ_EN the same way the design does.
module tb_freqdiv_ctrl;

    localparam int NW   = 4;
    localparam int PCW  = 16;
    localparam int WDOG = 16;
`ifdef FREQDIV_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wbs_stb_i = 1'b0;
    logic          wbs_cyc_i = 1'b0;
    logic          wbs_we_i = 1'b0;
    logic [3:0]    wbs_sel_i = 4'hF;
    logic [31:0]   wbs_adr_i = '0;
    logic [31:0]   wbs_dat_i = '0;
    logic          wbs_ack_o;
    logic [31:0]   wbs_dat_o;
    logic          div_wrap_i = 1'b0;
    logic          div_en_o;
    logic [NW-1:0] div_n_o;
    logic          irq_o;

    always #5 clk = ~clk;

    freqdiv_ctrl #(.NW(NW), .PCW(PCW), .WDOG(WDOG)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .div_wrap_i (div_wrap_i),
        .div_en_o   (div_en_o),
        .div_n_o    (div_n_o),
        .irq_o      (irq_o)
    );

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        logic [31:0] adr;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: divider-side behaviour described as "what the divider is doing"
    typedef enum int {P_IDLE, P_RUN, P_PEND, P_STOP} phase_e;
    phase_e      phase;
    bit          m_ctrl_en, m_ie, m_err, m_done, m_en, m_ack;
    int          m_div, m_n, m_pc, m_dwell;

    task automatic model_reset();
        phase = P_IDLE;
        m_ctrl_en = 0; m_ie = 0; m_err = 0; m_done = 0; m_en = 0; m_ack = 0;
        m_div = 2; m_n = 2; m_pc = 0; m_dwell = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] adr);
        logic [31:0] r;
        r = '0;
        if (adr[31:4] == 0) begin
            case (adr[3:2])
                2'd0: r = {30'd0, m_ie, m_ctrl_en};
                2'd1: r = 32'(m_div);
                2'd2: r = (m_n << 8) | (m_done << 3) | (m_err << 2)
                          | ((phase == P_PEND) << 1) | 32'(m_en);
                default: r = 32'(m_pc);
            endcase
        end
        return r;
    endfunction

    task automatic model_edge(input bit acc, input bit we, input logic [31:0] adr,
                              input logic [31:0] dat, input bit wrap);
        phase_e nphase = phase;
        int     nn = m_n, ndiv = m_div, npc = m_pc;
        bit     nen = m_en, nctrl = m_ctrl_en, nie = m_ie;
        bit     set_e = 0, set_d = 0, clr_e = 0, clr_d = 0;
        bit     timeout = (m_dwell == WDOG - 1);

        case (phase)
            P_IDLE: if (m_ctrl_en) begin nn = m_div; nen = 1; nphase = P_RUN; end
            P_RUN:  if (!m_ctrl_en) nphase = P_STOP;
                    else if (m_div != m_n) nphase = P_PEND;
            P_PEND: if (!m_ctrl_en) nphase = P_STOP;
                    else if (wrap || timeout) begin
                        nn = m_div; set_d = 1; set_e = !wrap; nphase = P_RUN;
                    end
            P_STOP: if (wrap || timeout) begin nen = 0; set_e = !wrap; nphase = P_IDLE; end
        endcase

        if (phase == P_IDLE && m_ctrl_en) npc = 0;
        else if (wrap && m_en && m_pc < (1 << PCW) - 1) npc = m_pc + 1;

        if (acc && we && adr[31:4] == 0) begin
            case (adr[3:2])
                2'd0: begin nctrl = dat[0]; nie = IRQ ? dat[1] : 1'b0; end
                2'd1: if (dat[3:0] >= 2) ndiv = dat[3:0]; else set_e = 1;
                2'd2: begin clr_e = dat[2]; clr_d = dat[3]; end
                default: ;
            endcase
        end

        m_err  = set_e ? 1'b1 : (clr_e ? 1'b0 : m_err);
        m_done = set_d ? 1'b1 : (clr_d ? 1'b0 : m_done);
        m_dwell = (nphase != phase || nphase == P_IDLE || nphase == P_RUN) ? 0 : m_dwell + 1;
        phase = nphase; m_n = nn; m_en = nen; m_pc = npc; m_div = ndiv;
        m_ctrl_en = nctrl; m_ie = nie; m_ack = acc;
    endtask

    // One clock of stimulus; called at a negedge, returns at the next negedge after checking outputs
    task automatic tick(input bit stb, input bit we, input logic [31:0] adr,
                        input logic [31:0] dat, input bit wrap);
        bit acc;
        exp_t e;
        wbs_stb_i = stb; wbs_cyc_i = stb; wbs_we_i = we;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = 4'hF; div_wrap_i = wrap;
        acc = stb && !m_ack;
        if (acc) begin
            e.is_read = !we;
            e.data    = model_read(adr);
            e.adr     = adr;
            sb.push_back(e);
        end
        model_edge(acc, we, adr, dat, wrap);
        @(negedge clk);
        check("div_en_o", 32'(div_en_o), 32'(m_en));
        check("div_n_o", 32'(div_n_o), 32'(m_n));
        check("irq_o", 32'(irq_o), 32'(IRQ && m_done && m_ie));
        check("wbs_ack_o", 32'(wbs_ack_o), 32'(m_ack));
    endtask

    task automatic wb_access(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                             input bit w0 = 0, input bit w1 = 0);
        tick(1, we, adr, dat, w0);
        tick(1, we, adr, dat, w1);
    endtask

    task automatic idle(input int n, input bit wrap = 0);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, wrap);
    endtask

    task automatic read_all();
        for (int a = 0; a <= 16; a += 4) wb_access(0, 32'(a), 0);
    endtask

    function automatic bit rnd_wrap(input int rate);
        if (rate == 0) return 0;
        return ($urandom_range(0, rate) == 0);
    endfunction

    // Scoreboard monitor: every ack consumes one expected response
    always @(negedge clk) begin
        if (rst_n && wbs_ack_o) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(wbs_ack_o), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.is_read) check($sformatf("read_0x%0h", e.adr), wbs_dat_o, e.data);
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_div_en", 32'(div_en_o), 32'd0);
        check("rst_div_n", 32'(div_n_o), 32'd2);
        check("rst_ack", 32'(wbs_ack_o), 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);
        rst_n = 1'b1;
        idle(2);
        read_all();

        // Start at ratio 6, count ten wraps
        wb_access(1, 32'h4, 6);
        wb_access(1, 32'h0, 1);
        idle(2);
        for (int i = 0; i < 10; i++) begin idle(1, 1); idle(2); end
        wb_access(0, 32'hC, 0);

        // Ratio change waits for the wrap
        wb_access(1, 32'h4, 9);
        idle(3);
        wb_access(0, 32'h8, 0);
        idle(1, 1);
        idle(1);
        wb_access(0, 32'h8, 0);

        // Illegal ratio, then W1C of err
        wb_access(1, 32'h4, 1);
        wb_access(0, 32'h4, 0);
        wb_access(0, 32'h8, 0);
        wb_access(1, 32'h4, 0);
        wb_access(1, 32'h8, 32'h4);
        wb_access(0, 32'h8, 0);

        // Watchdog forces a pending change
        wb_access(1, 32'h4, 12);
        idle(22);
        wb_access(0, 32'h8, 0);

        // Interrupt path
        wb_access(1, 32'h8, 32'hC);
        wb_access(1, 32'h0, 3);
        wb_access(1, 32'h4, 5);
        idle(2);
        idle(1, 1);
        idle(2);
        wb_access(1, 32'h8, 32'h8);
        idle(2);

        // DIV write coinciding with wrap in PEND
        wb_access(1, 32'h4, 7);
        idle(2);
        wb_access(1, 32'h4, 3, 1, 0);
        idle(3);
        idle(1, 1);
        idle(2);

        // Stop with en_req toggled back on before the wrap
        wb_access(1, 32'h0, 0);
        idle(2);
        wb_access(1, 32'h0, 1);
        idle(3);
        idle(1, 1);
        idle(3);
        wb_access(0, 32'h8, 0);

        // Stop forced by watchdog
        wb_access(1, 32'h0, 0);
        idle(20);
        wb_access(0, 32'h8, 0);
        wb_access(1, 32'h8, 32'hC);

        // PCOUNT saturation
        wb_access(1, 32'h0, 1);
        idle(65540, 1);
        wb_access(0, 32'hC, 0);

        // Randomized traffic
        for (int seg = 0; seg < 15; seg++) begin
            int rate;
            rate = ($urandom_range(0, 2) == 0) ? 0 : ($urandom_range(0, 1) ? 2 : 9);
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    logic [31:0] adr, dat;
                    bit we;
                    adr = 32'($urandom_range(0, 4) * 4);
                    we  = $urandom_range(0, 1);
                    case (adr)
                        32'h0:   dat = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3) & 2)
                                                                 : 32'($urandom_range(0, 3) | 1);
                        32'h4:   dat = 32'($urandom_range(0, 15));
                        default: dat = 32'($urandom_range(0, 15));
                    endcase
                    wb_access(we, adr, dat, rnd_wrap(rate), rnd_wrap(rate));
                end else begin
                    tick(0, 0, 0, 0, rnd_wrap(rate));
                end
            end
        end

        // Asynchronous reset between edges
        wb_access(1, 32'h0, 1);
        wb_access(1, 32'h4, 11);
        idle(4);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_div_en", 32'(div_en_o), 32'd0);
        check("async_rst_div_n", 32'(div_n_o), 32'd2);
        check("async_rst_irq", 32'(irq_o), 32'd0);
        check("async_rst_ack", 32'(wbs_ack_o), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        read_all();
        idle(2);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
